// File: rtl/minivan_acc.sv
// ---------------------------------------------------------------------------
// minivan_acc
//   Registered adder/accumulator stage. Each accepted request computes
//   a + b + OFFSET (ADD), folds it into a per-channel accumulator (ACC),
//   clears an accumulator (CLR) or loads one (LOAD). The result lands in a
//   one-entry output register with a valid/ready handshake.
//
//   Build option: define MINIVAN_ACC_SAT_EN to saturate results (output and
//   stored accumulator) at 2^WIDTH-1 instead of wrapping. out_ovf is the
//   same in both builds.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_op               00 ADD, 01 ACC, 10 CLR, 11 LOAD
//   in_ch               target channel
//   in_a, in_b          operands
//   out_valid/out_ready result handshake
//   out_data            result
//   out_ch              echoed channel
//   out_ovf             sum exceeded 2^WIDTH-1, or out-of-range channel
// ---------------------------------------------------------------------------
module minivan_acc #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int OFFSET   = 3,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [CHW-1:0]   in_ch,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CHW-1:0]   out_ch,
    output logic             out_ovf
);

`ifdef MINIVAN_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [WIDTH+1:0] OFF_X  = (WIDTH+2)'(OFFSET);
    localparam logic [CHW:0]     CH_LIM = (CHW+1)'(CHANNELS);

    // Any set bit above WIDTH means the sum exceeded 2^WIDTH-1.
    function automatic logic ovf_of(input logic [WIDTH+1:0] s);
        return |s[WIDTH+1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] fix(input logic [WIDTH+1:0] s);
        return (SAT_EN && ovf_of(s)) ? {WIDTH{1'b1}} : s[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] acc [CHANNELS];

    logic             accept;
    logic             ch_ok;
    logic [WIDTH-1:0] acc_rd;
    logic [WIDTH+1:0] s_add;
    logic [WIDTH+1:0] s_acc;
    logic [WIDTH-1:0] data_p0;
    logic             ovf_p0;
    logic             acc_we;
    logic [WIDTH-1:0] acc_wd;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Only reachable when CHANNELS is not a power of two.
    assign ch_ok  = ({1'b0, in_ch} < CH_LIM);
    assign acc_rd = ch_ok ? acc[in_ch] : '0;

    // Two guard bits hold the worst case 3*(2^WIDTH-1) + OFFSET.
    assign s_add = {2'b00, in_a} + {2'b00, in_b} + OFF_X;
    assign s_acc = s_add + {2'b00, acc_rd};

    always_comb begin
        data_p0 = '0;
        ovf_p0  = 1'b0;
        acc_we  = 1'b0;
        acc_wd  = '0;
        case (in_op)
            OP_ADD: begin
                data_p0 = fix(s_add);
                ovf_p0  = ovf_of(s_add);
            end
            OP_ACC: begin
                if (ch_ok) begin
                    data_p0 = fix(s_acc);
                    ovf_p0  = ovf_of(s_acc);
                    acc_we  = accept;
                    acc_wd  = fix(s_acc);
                end else begin
                    ovf_p0  = 1'b1;
                end
            end
            OP_CLR: begin
                if (ch_ok) begin
                    acc_we = accept;
                    acc_wd = '0;
                end else begin
                    ovf_p0 = 1'b1;
                end
            end
            default: begin
                if (ch_ok) begin
                    data_p0 = in_a;
                    acc_we  = accept;
                    acc_wd  = in_a;
                end else begin
                    ovf_p0  = 1'b1;
                end
            end
        endcase
    end

    // ---- stage boundary: accept edge -> accumulators and output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else if (acc_we) begin
            acc[in_ch] <= acc_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= data_p0;
            out_ch    <= in_ch;
            out_ovf   <= ovf_p0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
